// File: rtl/lt24_pixel_writer_if.sv
// Pixel-write handshake between the pixel generator (master) and the LT24 writer (slave).
interface lt24_pixel_writer_if;
    logic [7:0]  xAddr;
    logic [8:0]  yAddr;
    logic [15:0] pixelData;
    logic        pixelWrite;
    logic        pixelReady;
    logic        pixelDropped;

    modport master (
        output xAddr, yAddr, pixelData, pixelWrite,
        input  pixelReady, pixelDropped
    );

    modport slave (
        input  xAddr, yAddr, pixelData, pixelWrite,
        output pixelReady, pixelDropped
    );
endinterface

// File: rtl/lt24_pixel_writer.sv
// Turns accepted pixels into LT24 8080-style bus writes (window set, 0x2C, pixel data).
// Define LT24_ADDR_TRACK_EN to send raster-sequential pixels as a single data word.
module lt24_pixel_writer #(
    parameter int WIDTH   = 240,
    parameter int HEIGHT  = 320,
    parameter int WR_LOW  = 1,
    parameter int WR_HIGH = 1
) (
    input  logic                clock,
    input  logic                reset_n,
    lt24_pixel_writer_if.slave  pix,
    output logic                LT24Wr_n,
    output logic                LT24Rd_n,
    output logic                LT24CS_n,
    output logic                LT24RS,
    output logic [15:0]         LT24Data
);

    typedef enum logic [1:0] {IDLE, DROP, WR_LO, WR_HI} state_t;

    localparam logic [3:0] LAST_WORD = 4'd11;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  word_q, word_d;
    logic [7:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [15:0] pix_q, pix_d;
    logic        ready_q, ready_d;
    logic        dropped_q, dropped_d;
    logic        wr_n_q, wr_n_d;
    logic        cs_n_q, cs_n_d;
    logic        rs_q, rs_d;
    logic [15:0] data_q, data_d;
    logic [16:0] bw_s;
    logic        out_of_range_s;
    logic        seq_s;
    logic        done_s;

    // {RS, Data} for word idx of the 12-word sequence; idx 11 is the pixel itself.
    function automatic logic [16:0] bus_word(input logic [3:0] idx, input logic [7:0] x,
                                             input logic [8:0] y, input logic [15:0] p);
        logic [15:0] xw, yw, wm, hm;
        xw = {8'h00, x};
        yw = {7'h00, y};
        wm = 16'(WIDTH - 1);
        hm = 16'(HEIGHT - 1);
        case (idx)
            4'd0:    bus_word = {1'b0, 16'h002A};
            4'd1:    bus_word = {1'b1, 8'h00, xw[15:8]};
            4'd2:    bus_word = {1'b1, 8'h00, xw[7:0]};
            4'd3:    bus_word = {1'b1, 8'h00, wm[15:8]};
            4'd4:    bus_word = {1'b1, 8'h00, wm[7:0]};
            4'd5:    bus_word = {1'b0, 16'h002B};
            4'd6:    bus_word = {1'b1, 8'h00, yw[15:8]};
            4'd7:    bus_word = {1'b1, 8'h00, yw[7:0]};
            4'd8:    bus_word = {1'b1, 8'h00, hm[15:8]};
            4'd9:    bus_word = {1'b1, 8'h00, hm[7:0]};
            4'd10:   bus_word = {1'b0, 16'h002C};
            4'd11:   bus_word = {1'b1, p};
            default: bus_word = {1'b1, 16'h0000};
        endcase
    endfunction

    assign out_of_range_s = ({1'b0, pix.xAddr} >= 9'(WIDTH)) || ({1'b0, pix.yAddr} >= 10'(HEIGHT));

`ifdef LT24_ADDR_TRACK_EN
    logic [7:0] last_x_q, last_x_d;
    logic [8:0] last_y_q, last_y_d;
    logic       addr_valid_q, addr_valid_d;
    logic [7:0] next_x_s;
    logic [8:0] next_y_s;

    // Expected auto-increment address and the tracking update at sequence completion.
    always_comb begin
        if (last_x_q == 8'(WIDTH - 1)) begin
            next_x_s = 8'd0;
            if (last_y_q == 9'(HEIGHT - 1)) begin
                next_y_s = 9'd0;
            end else begin
                next_y_s = 9'(last_y_q + 9'd1);
            end
        end else begin
            next_x_s = 8'(last_x_q + 8'd1);
            next_y_s = last_y_q;
        end
        seq_s = addr_valid_q && (pix.xAddr == next_x_s) && (pix.yAddr == next_y_s);
        if (done_s) begin
            last_x_d     = x_q;
            last_y_d     = y_q;
            addr_valid_d = 1'b1;
        end else begin
            last_x_d     = last_x_q;
            last_y_d     = last_y_q;
            addr_valid_d = addr_valid_q;
        end
    end

    // Panel address tracking registers; cleared by reset so the next pixel resends the window.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_x_q     <= 8'd0;
            last_y_q     <= 9'd0;
            addr_valid_q <= 1'b0;
        end else begin
            last_x_q     <= last_x_d;
            last_y_q     <= last_y_d;
            addr_valid_q <= addr_valid_d;
        end
    end
`else
    assign seq_s = 1'b0;
`endif

    // Next-state and next-output logic for the bus write sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        x_d       = x_q;
        y_d       = y_q;
        pix_d     = pix_q;
        ready_d   = ready_q;
        dropped_d = 1'b0;
        wr_n_d    = wr_n_q;
        cs_n_d    = cs_n_q;
        rs_d      = rs_q;
        data_d    = data_q;
        bw_s      = 17'h00000;
        done_s    = 1'b0;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (ready_q && pix.pixelWrite) begin
                    ready_d = 1'b0;
                    if (out_of_range_s) begin
                        dropped_d = 1'b1;
                        state_d   = DROP;
                    end else begin
                        x_d     = pix.xAddr;
                        y_d     = pix.yAddr;
                        pix_d   = pix.pixelData;
                        word_d  = seq_s ? LAST_WORD : 4'd0;
                        bw_s    = bus_word(word_d, pix.xAddr, pix.yAddr, pix.pixelData);
                        rs_d    = bw_s[16];
                        data_d  = bw_s[15:0];
                        wr_n_d  = 1'b0;
                        cs_n_d  = 1'b0;
                        cnt_d   = 16'd0;
                        state_d = WR_LO;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            DROP: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            WR_LO: begin
                if (cnt_q == 16'(WR_LOW - 1)) begin
                    wr_n_d  = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = WR_HI;
                end else begin
                    cnt_d = 16'(cnt_q + 16'd1);
                end
            end
            WR_HI: begin
                if (cnt_q == 16'(WR_HIGH - 1)) begin
                    cnt_d = 16'd0;
                    if (word_q == LAST_WORD) begin
                        cs_n_d  = 1'b1;
                        ready_d = 1'b1;
                        done_s  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        word_d  = 4'(word_q + 4'd1);
                        bw_s    = bus_word(word_d, x_q, y_q, pix_q);
                        rs_d    = bw_s[16];
                        data_d  = bw_s[15:0];
                        wr_n_d  = 1'b0;
                        state_d = WR_LO;
                    end
                end else begin
                    cnt_d = 16'(cnt_q + 16'd1);
                end
            end
            default: begin
                wr_n_d  = 1'b1;
                cs_n_d  = 1'b1;
                ready_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered bus/handshake outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            word_q    <= 4'd0;
            x_q       <= 8'd0;
            y_q       <= 9'd0;
            pix_q     <= 16'h0000;
            ready_q   <= 1'b0;
            dropped_q <= 1'b0;
            wr_n_q    <= 1'b1;
            cs_n_q    <= 1'b1;
            rs_q      <= 1'b1;
            data_q    <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            x_q       <= x_d;
            y_q       <= y_d;
            pix_q     <= pix_d;
            ready_q   <= ready_d;
            dropped_q <= dropped_d;
            wr_n_q    <= wr_n_d;
            cs_n_q    <= cs_n_d;
            rs_q      <= rs_d;
            data_q    <= data_d;
        end
    end

    assign pix.pixelReady   = ready_q;
    assign pix.pixelDropped = dropped_q;
    assign LT24Wr_n         = wr_n_q;
    assign LT24Rd_n         = 1'b1;
    assign LT24CS_n         = cs_n_q;
    assign LT24RS           = rs_q;
    assign LT24Data         = data_q;

endmodule

// File: tb/tb_lt24_pixel_writer.sv
// Directed bench for lt24_pixel_writer: default-timing instance plus a WR_LOW=3/WR_HIGH=2 instance.
module tb_lt24_pixel_writer;

`ifdef LT24_ADDR_TRACK_EN
    localparam bit TRK = 1'b1;
`else
    localparam bit TRK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    int          n_pass = 0;
    int          n_tot = 0;

    lt24_pixel_writer_if if_a();
    lt24_pixel_writer_if if_b();

    logic        a_wr_n, a_rd_n, a_cs_n, a_rs;
    logic [15:0] a_data;
    logic        b_wr_n, b_rd_n, b_cs_n, b_rs;
    logic [15:0] b_data;

    lt24_pixel_writer dut (
        .clock(clock), .reset_n(reset_n), .pix(if_a.slave),
        .LT24Wr_n(a_wr_n), .LT24Rd_n(a_rd_n), .LT24CS_n(a_cs_n), .LT24RS(a_rs), .LT24Data(a_data)
    );

    lt24_pixel_writer #(.WR_LOW(3), .WR_HIGH(2)) dut_slow (
        .clock(clock), .reset_n(reset_n), .pix(if_b.slave),
        .LT24Wr_n(b_wr_n), .LT24Rd_n(b_rd_n), .LT24CS_n(b_cs_n), .LT24RS(b_rs), .LT24Data(b_data)
    );

    always #5 clock = ~clock;

    logic [16:0] words[$];
    int          cs_bad = 0;
    int          cs_fall = 0;
    int          b_strobes = 0;

    // Panel-side view: record every word latched on the rising Wr_n edge.
    always @(posedge a_wr_n) begin
        if (reset_n) begin
            words.push_back({a_rs, a_data});
            if (a_cs_n !== 1'b0) cs_bad++;
        end
    end

    always @(negedge a_cs_n) cs_fall++;

    always @(posedge b_wr_n) if (reset_n) b_strobes++;

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic accept_a(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d);
        int t;
        t = 0;
        while (if_a.pixelReady !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (t >= 100) chk("ready_timeout", 32'(if_a.pixelReady), 32'd1);
        if_a.xAddr      = x;
        if_a.yAddr      = y;
        if_a.pixelData  = d;
        if_a.pixelWrite = 1'b1;
        @(posedge clock);
        #1;
        if_a.pixelWrite = 1'b0;
    endtask

    task automatic send_px(input logic [7:0] x, input logic [8:0] y, input logic [15:0] d,
                           input bit shrt, input string tag);
        logic [16:0] e[12];
        logic [15:0] xw, yw;
        int lowc, nexp;
        words.delete();
        cs_bad = 0;
        xw = {8'h00, x};
        yw = {7'h00, y};
        e[0]  = {1'b0, 16'h002A};
        e[1]  = {1'b1, 8'h00, xw[15:8]};
        e[2]  = {1'b1, 8'h00, xw[7:0]};
        e[3]  = {1'b1, 16'h0000};
        e[4]  = {1'b1, 16'h00EF};
        e[5]  = {1'b0, 16'h002B};
        e[6]  = {1'b1, 8'h00, yw[15:8]};
        e[7]  = {1'b1, 8'h00, yw[7:0]};
        e[8]  = {1'b1, 16'h0001};
        e[9]  = {1'b1, 16'h003F};
        e[10] = {1'b0, 16'h002C};
        e[11] = {1'b1, d};
        accept_a(x, y, d);
        lowc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (if_a.pixelReady === 1'b1) break;
            lowc++;
        end
        nexp = shrt ? 1 : 12;
        chk({tag, " ready_low"}, 32'(lowc), shrt ? 32'd2 : 32'd24);
        chk({tag, " nwords"}, 32'(words.size()), 32'(nexp));
        for (int i = 0; i < nexp; i++) begin
            if (i < words.size())
                chk($sformatf("%s word%0d", tag, i), 32'(words[i]), 32'(e[shrt ? 11 : i]));
        end
        chk({tag, " cs_low"}, 32'(cs_bad), 32'd0);
        chk({tag, " cs_idle"}, 32'(a_cs_n), 32'd1);
    endtask

    task automatic drop_px(input logic [7:0] x, input logic [8:0] y, input string tag);
        words.delete();
        cs_fall = 0;
        accept_a(x, y, 16'hBEEF);
        @(negedge clock);
        chk({tag, " dropped"}, 32'(if_a.pixelDropped), 32'd1);
        chk({tag, " ready_lo"}, 32'(if_a.pixelReady), 32'd0);
        @(negedge clock);
        chk({tag, " dropped_end"}, 32'(if_a.pixelDropped), 32'd0);
        chk({tag, " ready_back"}, 32'(if_a.pixelReady), 32'd1);
        chk({tag, " no_words"}, 32'(words.size()), 32'd0);
        chk({tag, " no_cs"}, 32'(cs_fall), 32'd0);
        chk({tag, " wr_idle"}, 32'(a_wr_n), 32'd1);
    endtask

    initial begin
        int lowc, wlo, whi;
        if_a.xAddr = 8'd0; if_a.yAddr = 9'd0; if_a.pixelData = 16'h0000; if_a.pixelWrite = 1'b0;
        if_b.xAddr = 8'd0; if_b.yAddr = 9'd0; if_b.pixelData = 16'h0000; if_b.pixelWrite = 1'b0;

        // Reset values while held, then ready one edge after release.
        repeat (3) @(negedge clock);
        chk("rst wr_n", 32'(a_wr_n), 32'd1);
        chk("rst rd_n", 32'(a_rd_n), 32'd1);
        chk("rst cs_n", 32'(a_cs_n), 32'd1);
        chk("rst rs", 32'(a_rs), 32'd1);
        chk("rst data", 32'(a_data), 32'h0000);
        chk("rst ready", 32'(if_a.pixelReady), 32'd0);
        chk("rst dropped", 32'(if_a.pixelDropped), 32'd0);
        reset_n = 1'b1;
        #1;
        chk("rel ready_pre", 32'(if_a.pixelReady), 32'd0);
        @(negedge clock);
        chk("rel ready", 32'(if_a.pixelReady), 32'd1);

        send_px(8'd5, 9'd7, 16'hF800, 1'b0, "p5_7");
        send_px(8'd6, 9'd7, 16'h07E0, TRK, "p6_7");
        drop_px(8'd240, 9'd0, "drop_x");
        drop_px(8'd0, 9'd320, "drop_y");
        send_px(8'd7, 9'd7, 16'h1234, TRK, "p7_7");
        send_px(8'd239, 9'd7, 16'hAAAA, 1'b0, "p239_7");
        send_px(8'd0, 9'd8, 16'h5555, TRK, "p0_8");
        send_px(8'd239, 9'd319, 16'h0F0F, 1'b0, "p239_319");
        send_px(8'd0, 9'd0, 16'hF0F0, TRK, "p0_0");
        chk("rd_n const", 32'(a_rd_n), 32'd1);

        // Reset during word 6 (0x002B) of a full sequence.
        words.delete();
        accept_a(8'd100, 9'd50, 16'h4321);
        repeat (10) @(posedge clock);
        #1;
        chk("mid words", 32'(words.size()), 32'd5);
        chk("mid data", 32'({a_rs, a_data}), 32'({1'b0, 16'h002B}));
        reset_n = 1'b0;
        #1;
        chk("mid cs_n", 32'(a_cs_n), 32'd1);
        chk("mid wr_n", 32'(a_wr_n), 32'd1);
        chk("mid ready", 32'(if_a.pixelReady), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        send_px(8'd7, 9'd7, 16'h00FF, 1'b0, "post_rst");

        // Stretched strobe timing on the WR_LOW=3 / WR_HIGH=2 instance.
        b_strobes = 0;
        @(negedge clock);
        if_b.xAddr = 8'd5; if_b.yAddr = 9'd7; if_b.pixelData = 16'hF800; if_b.pixelWrite = 1'b1;
        @(posedge clock);
        #1;
        if_b.pixelWrite = 1'b0;
        lowc = 0; wlo = 0; whi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (if_b.pixelReady === 1'b1) break;
            lowc++;
            if (b_wr_n === 1'b0) wlo++;
            else whi++;
        end
        chk("slow ready_low", 32'(lowc), 32'd60);
        chk("slow wr_low", 32'(wlo), 32'd36);
        chk("slow wr_high", 32'(whi), 32'd24);
        chk("slow strobes", 32'(b_strobes), 32'd12);
        chk("slow last", 32'({b_rs, b_data}), 32'({1'b1, 16'hF800}));
        chk("slow cs_idle", 32'(b_cs_n), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
